// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arb_pkg
// Purpose  : Shared constants for the data-memory arbiter: status mode codes
//            and the round-robin pointer width helper.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

  localparam logic [1:0] MODE_IDLE   = 2'b00;
  localparam logic [1:0] MODE_LOAD   = 2'b01;
  localparam logic [1:0] MODE_RUN    = 2'b10;
  localparam logic [1:0] MODE_UNLOAD = 2'b11;

  // Ceiling log2 with a floor of 1 so a pointer always has at least one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Core-side request/grant bus of the data-memory arbiter. The cores
//            use the master modport, the arbiter the slave modport.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if #(
  parameter int N_CORES = 4,
  parameter int DW      = 16,
  parameter int AW      = 16
);

  logic [N_CORES-1:0]    core_req;
  logic [N_CORES-1:0]    core_wr_en;
  logic [N_CORES*AW-1:0] core_addr;
  logic [N_CORES*DW-1:0] core_wdata;
  logic [N_CORES-1:0]    core_lock;
  logic [N_CORES-1:0]    core_done;
  logic [N_CORES-1:0]    core_gnt;
  logic [N_CORES-1:0]    core_rvalid;
  logic [DW-1:0]         core_rdata;

  modport master (
    output core_req, core_wr_en, core_addr, core_wdata, core_lock, core_done,
    input  core_gnt, core_rvalid, core_rdata
  );

  modport slave (
    input  core_req, core_wr_en, core_addr, core_wdata, core_lock, core_done,
    output core_gnt, core_rvalid, core_rdata
  );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Candidates are req & ~mask; the
//            search starts at ptr and wraps. Produces a one-hot grant, the
//            winner index and a valid flag.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] winner,
  output logic          valid
);

  logic [N-1:0] elig;
  logic [N-1:0] rot;

  assign elig = req & ~mask;
  // Rotate so bit 0 is the core at ptr; the first set bit is then the winner.
  assign rot  = N'({elig, elig} >> ptr);

  // Priority-encode the rotated vector and map the offset back to a core index.
  always_comb begin
    int w;
    w      = 0;
    valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!valid && rot[k]) begin
        valid = 1'b1;
        w     = int'(ptr) + k;
        if (w >= N) w = w - N;
      end
    end
    winner = PW'(w);
    gnt    = valid ? (N'(1) << winner) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one synchronous DRAM between N_CORES cores and the com
//            port. RUN mode grants cores round-robin (registered grant, DRAM
//            access in the grant cycle, rvalid one cycle later for reads);
//            LOAD/UNLOAD hand the DRAM to the com port. Also aggregates the
//            per-core done flags into end_process.
// Options  : DMEM_ARB_LOCK_EN - a granted core holding core_lock keeps the bus
//            across consecutive cycles until the lock drops or RUN is left.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_CORES = 4,
  parameter int DW      = 16,
  parameter int AW      = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     status,
  input  logic [DW-1:0]  com_data_in,
  input  logic [AW-1:0]  com_addr,
  input  logic           com_wr_en,
  output logic [DW-1:0]  com_data_out,
  dmem_arbiter_if.slave  bus,
  output logic [AW-1:0]  DM_addr,
  output logic [DW-1:0]  DM_data_in,
  output logic           DM_write_en,
  input  logic [DW-1:0]  DM_out,
  output logic           end_process
);

  localparam int PW = clog2(N_CORES);

  logic [N_CORES-1:0] gnt_q, gnt_d;
  logic [PW-1:0]      gnt_idx_q, gnt_idx_d;
  logic [N_CORES-1:0] rvalid_q, rvalid_d;
  logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [AW-1:0]      dm_addr_q, dm_addr_d;
  logic               end_process_q, end_process_d;

  logic               run;
  logic [N_CORES-1:0] arb_req;
  logic [N_CORES-1:0] arb_mask;
  logic [N_CORES-1:0] arb_gnt;
  logic [PW-1:0]      arb_winner;
  logic               arb_valid;

  assign run = (status == MODE_RUN);

`ifdef DMEM_ARB_LOCK_EN
  logic [N_CORES-1:0] lock_q, lock_d;
  logic [N_CORES-1:0] lock_hold;

  // Lock stays with the core that took it while granted, as long as it keeps core_lock high.
  assign lock_hold = (gnt_q | lock_q) & bus.core_lock;
  assign lock_d    = run ? lock_hold : '0;

  // Lock owner register; leaving RUN breaks the lock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lock_q <= '0;
    else        lock_q <= lock_d;
  end
`else
  logic lock_unused;
  assign lock_unused = ^bus.core_lock;
`endif

  // Arbiter candidates: normally all requesters minus the core granted this cycle;
  // under a held lock only the lock owner is eligible.
  always_comb begin
    arb_req  = bus.core_req;
    arb_mask = gnt_q;
`ifdef DMEM_ARB_LOCK_EN
    if (|lock_hold) begin
      arb_req  = lock_hold & bus.core_req;
      arb_mask = '0;
    end
`endif
  end

  rr_arbiter #(
    .N  (N_CORES),
    .PW (PW)
  ) u_rr (
    .req    (arb_req),
    .mask   (arb_mask),
    .ptr    (rr_ptr_q),
    .gnt    (arb_gnt),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // DRAM mux: an asserted grant always finishes its access, even if status just left RUN.
  always_comb begin
    DM_addr     = dm_addr_q;
    DM_data_in  = '0;
    DM_write_en = 1'b0;
    if (|gnt_q) begin
      DM_addr     = bus.core_addr[int'(gnt_idx_q)*AW +: AW];
      DM_data_in  = bus.core_wdata[int'(gnt_idx_q)*DW +: DW];
      DM_write_en = bus.core_wr_en[gnt_idx_q];
    end else if (status == MODE_LOAD) begin
      DM_addr     = com_addr;
      DM_data_in  = com_data_in;
      DM_write_en = com_wr_en;
    end else if (status == MODE_UNLOAD) begin
      DM_addr     = com_addr;
      DM_data_in  = com_data_in;
    end
  end

  // Next grant, pointer, rvalid and done aggregation.
  always_comb begin
    gnt_d     = '0;
    gnt_idx_d = gnt_idx_q;
    rr_ptr_d  = rr_ptr_q;
    if (run && arb_valid) begin
      gnt_d     = arb_gnt;
      gnt_idx_d = arb_winner;
      rr_ptr_d  = (arb_winner == PW'(N_CORES - 1)) ? '0 : arb_winner + 1'b1;
    end
    rvalid_d      = gnt_q & ~bus.core_wr_en;
    end_process_d = run & (&bus.core_done);
    dm_addr_d     = DM_addr;
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_q         <= '0;
      gnt_idx_q     <= '0;
      rvalid_q      <= '0;
      rr_ptr_q      <= '0;
      dm_addr_q     <= '0;
      end_process_q <= 1'b0;
    end else begin
      gnt_q         <= gnt_d;
      gnt_idx_q     <= gnt_idx_d;
      rvalid_q      <= rvalid_d;
      rr_ptr_q      <= rr_ptr_d;
      dm_addr_q     <= dm_addr_d;
      end_process_q <= end_process_d;
    end
  end

  assign bus.core_gnt    = gnt_q;
  assign bus.core_rvalid = rvalid_q;
  assign bus.core_rdata  = DM_out;
  assign com_data_out    = DM_out;
  assign end_process     = end_process_q;

endmodule
`default_nettype wire
